// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: divider FSM encoding and width constants.
package mdu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 32;

  localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract, keep or restore.
// Purely combinational, zero latency; no flow control.
module div_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvsr,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, i_dvsr};

  // The sign bit of the WIDTH+1-bit difference decides keep vs restore.
  always_comb begin
    o_rem = w_shift[WIDTH-1:0];
    o_quo = {i_quo[WIDTH-2:0], 1'b0};
    if (!w_diff[WIDTH]) begin
      o_rem = w_diff[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mdu_divider.sv
// Iterative DIV/DIVU for the execute stage; result WIDTH+1 cycles after accept (1 for divide-by-zero).
// Holds the upstream pipeline via o_stall while busy; starts outside IDLE are ignored, annul aborts.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_is_signed,
  input  logic             i_annul,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_stall,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam int               DIV0_REP = (WIDTH + DIV_WIDTH - 1) / DIV_WIDTH;
  localparam logic [WIDTH-1:0] W_DIV0   = WIDTH'({DIV0_REP{DIV0_QUOT}});

  div_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic             r_qsign;
  logic             r_rsign;
  logic             r_ready;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_lo_fix;
  logic [WIDTH-1:0] w_hi_fix;
  logic             w_accept;

  assign w_dvd_neg = i_is_signed & i_dividend[WIDTH-1];
  assign w_dvs_neg = i_is_signed & i_divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -i_dividend : i_dividend;
  assign w_dvs_mag = w_dvs_neg ? -i_divisor : i_divisor;
  assign w_accept  = (r_state == ST_IDLE) & i_start & ~i_annul;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_quo  (r_quo),
    .i_dvsr (r_dvsr),
    .o_rem  (w_rem_nxt),
    .o_quo  (w_quo_nxt)
  );

  // Sign fix-up on the final iteration's output so hi/lo are valid in the DONE cycle.
  assign w_lo_fix = r_qsign ? -w_quo_nxt : w_quo_nxt;
  assign w_hi_fix = r_rsign ? -w_rem_nxt : w_rem_nxt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvsr  <= '0;
      r_qsign <= 1'b0;
      r_rsign <= 1'b0;
      r_ready <= 1'b0;
      r_lo    <= '0;
      r_hi    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rem   <= '0;
            r_quo   <= w_dvd_mag;
            r_dvsr  <= w_dvs_mag;
            r_qsign <= w_dvd_neg ^ w_dvs_neg;
            r_rsign <= w_dvd_neg;
            r_cnt   <= '0;
            if (i_divisor == '0) begin
              r_lo    <= W_DIV0;
              r_hi    <= i_dividend;
              r_ready <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (i_annul) begin
            r_state <= ST_IDLE;
          end else begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_CNT) begin
              r_lo    <= w_lo_fix;
              r_hi    <= w_hi_fix;
              r_ready <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_ready <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_stall = w_accept | (r_state == ST_BUSY);
  assign o_ready = r_ready;
  assign o_lo    = r_lo;
  assign o_hi    = r_hi;

endmodule

// File: tb/tb_mdu_divider.sv
// Directed bench for mdu_divider: transaction-level model checked every cycle plus literal expectations.
module tb_mdu_divider;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic        i_is_signed = 1'b0;
  logic        i_annul = 1'b0;
  logic [31:0] i_dividend = '0;
  logic [31:0] i_divisor = '0;
  logic        o_stall;
  logic        o_ready;
  logic [31:0] o_lo;
  logic [31:0] o_hi;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mdu_divider dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_is_signed (i_is_signed),
    .i_annul     (i_annul),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_stall     (o_stall),
    .o_ready     (o_ready),
    .o_lo        (o_lo),
    .o_hi        (o_hi)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Architectural result {hi, lo} straight from the ISA definition.
  function automatic logic [63:0] model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[31:0];
      r  = sr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  logic        m_valid = 1'b0;
  int          m_left = 0;
  logic        m_ready = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_pend = '0;

  // m_left counts the cycles still needed before the result appears.
  always @(posedge clk) begin
    if (i_reset) begin
      m_valid <= 1'b1;
      m_left  <= 0;
      m_ready <= 1'b0;
      m_hi    <= '0;
      m_lo    <= '0;
    end else if (m_ready) begin
      m_ready <= 1'b0;
    end else if (m_left > 0) begin
      if (i_annul) begin
        m_left <= 0;
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          {m_hi, m_lo} <= m_pend;
          m_ready      <= 1'b1;
        end
      end
    end else if (i_start && !i_annul) begin
      if (i_divisor == 32'd0) begin
        {m_hi, m_lo} <= model_div(i_is_signed, i_dividend, i_divisor);
        m_ready      <= 1'b1;
      end else begin
        m_pend <= model_div(i_is_signed, i_dividend, i_divisor);
        m_left <= 32;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_stall", {31'd0, o_stall}, {31'd0, (m_left > 0) || (!m_ready && i_start && !i_annul)});
      chk("cyc_ready", {31'd0, o_ready}, {31'd0, m_ready});
      chk("cyc_lo", o_lo, m_lo);
      chk("cyc_hi", o_hi, m_hi);
    end
  end

  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input int exp_lat, input int poke);
    int lat;
    int stalls;
    @(posedge clk); #1;
    i_start = 1'b1; i_is_signed = sgn; i_dividend = a; i_divisor = b;
    @(negedge clk);
    stalls = int'(o_stall);
    @(posedge clk); #1;
    i_start = 1'b0;
    lat = 0;
    while (1) begin
      @(negedge clk);
      if (o_ready || lat >= 100) break;
      stalls += int'(o_stall);
      @(posedge clk); #1;
      lat++;
      if (poke > 0) begin
        i_start = (lat == poke); i_dividend = 32'hDEAD_BEEF; i_divisor = 32'd3;
      end
    end
    i_start = 1'b0;
    chk("latency", lat, exp_lat);
    chk("stall_cycles", stalls, exp_lat + 1);
    chk("lit_lo", o_lo, exp_lo);
    chk("lit_hi", o_hi, exp_hi);
    chk("model_lo", m_lo, exp_lo);
    chk("model_hi", m_hi, exp_hi);
    @(negedge clk);
    chk("ready_pulse_end", {31'd0, o_ready}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    chk("rst_stall", {31'd0, o_stall}, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd0);
    chk("rst_lo", o_lo, 32'd0);
    chk("rst_hi", o_hi, 32'd0);

    do_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 32, 0);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32, 0);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 32, 0);
    do_div(1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 0, 0);
    do_div(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 0, 0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32, 0);
    do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32, 0);
    do_div(1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFE, 32, 0);

    // Abort on what would be the tenth iteration; previous result must survive.
    @(posedge clk); #1;
    i_start = 1'b1; i_is_signed = 1'b0; i_dividend = 32'd1000; i_divisor = 32'd10;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (9) @(posedge clk);
    #1 i_annul = 1'b1;
    @(posedge clk); #1;
    i_annul = 1'b0;
    @(negedge clk);
    chk("annul_stall", {31'd0, o_stall}, 32'd0);
    chk("annul_ready", {31'd0, o_ready}, 32'd0);
    chk("annul_lo", o_lo, 32'd2);
    chk("annul_hi", o_hi, 32'hFFFF_FFFE);
    repeat (2) @(posedge clk);
    do_div(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 32, 0);

    do_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 32, 3);

    // Reset together with start while busy.
    @(posedge clk); #1;
    i_start = 1'b1; i_is_signed = 1'b0; i_dividend = 32'd100; i_divisor = 32'd7;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (5) @(posedge clk);
    #1 i_reset = 1'b1; i_start = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0; i_start = 1'b0;
    @(negedge clk);
    chk("rst2_stall", {31'd0, o_stall}, 32'd0);
    chk("rst2_ready", {31'd0, o_ready}, 32'd0);
    chk("rst2_lo", o_lo, 32'd0);
    chk("rst2_hi", o_hi, 32'd0);

    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 32, 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mdu_divider.md
Name: mdu_divider

Overview:
- Iterative radix-2 restoring divider for MIPS32 DIV/DIVU, placed in the execute stage.
- Consumes operands from the ID/EX pipeline register.
- Produces the HI/LO write data.
- Drives the stall request that deasserts the enables of the upstream enable-register pipeline stages (en = ~stall) for the duration of a division.

Parameters:
- WIDTH, 32, operand and result width in bits; must be even and at least 4.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  input  1  request a divide; accepted only in IDLE.
- is_signed  input  1  1 = DIV (signed), 0 = DIVU; sampled with start.
- annul  input  1  pipeline flush (exception/branch); aborts an in-flight divide.
- dividend  input  WIDTH  rs operand; sampled with start.
- divisor  input  WIDTH  rt operand; sampled with start.
- stall  output  1  pipeline hold request to the upstream enable registers.
- ready  output  1  one-cycle pulse; hi/lo valid from this cycle.
- lo  output  WIDTH  quotient.
- hi  output  WIDTH  remainder.

Behaviour:
- Reset: state=IDLE, counter=0, ready=0, stall=0, hi=0, lo=0. Reset wins over start and annul in the same cycle.
- States: IDLE, BUSY, DONE.
- IDLE -> BUSY on start & ~annul. On that edge the block latches:
  - |dividend| and |divisor| (two's-complement magnitude when is_signed, else the raw values);
  - the quotient sign, qsign = dividend[MSB]^divisor[MSB] when signed;
  - the remainder sign, rsign = dividend[MSB] when signed;
  - partial remainder = 0, counter = 0.
- Divide-by-zero (divisor==0) at start: go straight to DONE with lo = all ones and hi = dividend (raw). No iteration.
- BUSY: one quotient bit per cycle.
  - Shift {rem, quo} left 1.
  - Trial-subtract the divisor magnitude from the WIDTH+1-bit remainder.
  - If non-negative, keep the difference and set the quotient LSB to 1.
  - counter++. After WIDTH iterations (counter==WIDTH-1 on the edge), go to DONE.
- DONE (one cycle):
  - hi/lo registers take the sign-corrected results: quotient negated if qsign, remainder negated if rsign.
  - ready=1 is registered from this state, i.e. high during the DONE cycle with hi/lo already valid. Implement by registering the result on the BUSY->DONE edge.
  - Next edge -> IDLE.
- Latency: start accepted at edge T; ready high in the cycle following edge T+WIDTH (33 cycles for WIDTH=32). Divide-by-zero: ready high in the cycle following edge T.
- stall = (state==IDLE & start & ~annul) | (state==BUSY). Combinational; low in DONE so the pipeline advances exactly when the result is valid.
- hi/lo hold their last value until the next DONE; they do not change during BUSY.
- start while BUSY or DONE: ignored, with no effect on state.
- annul in BUSY or DONE: next state IDLE, ready=0, hi/lo keep their previous values. annul in IDLE suppresses acceptance of start.
- Overflow -2^31 / -1 (signed): lo=0x80000000, hi=0. This falls out of the magnitude arithmetic and must not trap.
- All arithmetic is modulo 2^WIDTH except the WIDTH+1-bit trial-subtract.

Decomposition:
- Shared package mdu_pkg holds:
  - the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - DIV_WIDTH=32;
  - constant DIV0_QUOT = all ones.
- One combinational sub-module, div_step: inputs rem, quo, divisor magnitude; outputs next rem and next quo for one restoring iteration. The top module holds the FSM, counter, sign fix-up and output registers.

Test Plan:
- Unsigned: 100/7, is_signed=0 -> lo=14, hi=2, ready in the cycle after edge T+32, stall high for exactly 33 cycles.
- Signed: -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also 7/-2 -> lo=-3, hi=1.
- Divide-by-zero: 0x12345678/0 -> lo=0xFFFFFFFF, hi=0x12345678, ready 1 cycle after acceptance, no BUSY cycles.
- Overflow: 0x80000000 / 0xFFFFFFFF signed -> lo=0x80000000, hi=0. The same operands unsigned -> lo=0, hi=0x80000000.
- Annul at iteration 10 -> next cycle IDLE, stall=0, no ready pulse, hi/lo equal the prior result. A new start two cycles later completes normally.
- Reset asserted mid-BUSY together with start -> next cycle IDLE with all outputs 0. start asserted during BUSY is ignored (the result matches the first operands).
